reference_sequencer: RTL and testbench

- Requesting end of the reference-buffer index/sample interface.
- On a start pulse, issues one full circular sweep of indices to the reference buffer, beginning at a programmable start index (CAF lag offset).
- Collects the returned I/Q samples, which arrive at fixed one-cycle latency and cannot be stalled.
- Forwards the samples as a flow-controlled AXI-stream with tlast, and uses credit-based issue so that no sample is ever dropped under downstream backpressure.

---
 rtl/reference_sequencer_pkg.sv | 21 ++
 rtl/reference_sequencer_if.sv | 15 +
 rtl/reference_sequencer_fifo.sv | 58 +++++
 rtl/reference_sequencer.sv | 143 ++++++++++++++
 tb/tb_reference_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reference_sequencer_pkg.sv
// rtl/reference_sequencer_pkg.sv - shared types and constants for the reference sequencer
// Port summary: none (package).
package reference_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    localparam int default_i_bits = 12;
    localparam int default_q_bits = 12;

    // One FIFO entry: {I, Q, last}
    localparam int sample_bits = default_i_bits + default_q_bits + 1;

    function automatic int sample_width(input int ib, input int qb);
        return ib + qb + 1;
    endfunction

endpackage

// File: rtl/reference_sequencer_if.sv
// rtl/reference_sequencer_if.sv - output sample stream interface
// Port summary: tvalid/tdata/tlast driven by master, tready driven by slave.
interface reference_sequencer_if
    import reference_pkg::*;
#(
    parameter int width = default_i_bits + default_q_bits
);
    logic             tvalid;
    logic             tready;
    logic [width-1:0] tdata;
    logic             tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/reference_sequencer_fifo.sv
// rtl/reference_sequencer_fifo.sv - synchronous sample FIFO with asynchronous reset
// Ports: clk, rst, push/push_data in, pop in, pop_data (head entry), count, full, empty.
module reference_sample_fifo #(
    parameter int width = 25,
    parameter int depth = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [width-1:0]           push_data,
    input  logic                       pop,
    output logic [width-1:0]           pop_data,
    output logic [$clog2(depth):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == cw'(depth));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + cw'(1);
                2'b01:   count <= count - cw'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/reference_sequencer.sv
// rtl/reference_sequencer.sv - sweeps reference buffer indices and streams returned I/Q samples
// Ports: clk, rst; start/start_index in, busy/done out; index request (m_axis_index_*),
// returned sample (s_axis_data_tready, i, q, s_axis_data_tvalid); m_axis output stream interface.
module reference_sequencer
    import reference_pkg::*;
#(
    parameter int buffer_length = 10,
    parameter int buffer_bits   = 4,
    parameter int i_bits        = default_i_bits,
    parameter int q_bits        = default_q_bits,
    parameter int fifo_depth    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [buffer_bits-1:0]   start_index,
    output logic                     busy,
    output logic                     done,
    output logic                     m_axis_index_tvalid,
    output logic [buffer_bits-1:0]   m_axis_index_tdata,
    input  logic                     s_axis_data_tready,
    input  logic [i_bits-1:0]        i,
    input  logic [q_bits-1:0]        q,
    input  logic                     s_axis_data_tvalid,
    reference_sequencer_if.master    m_axis
);
    localparam int sw = sample_width(i_bits, q_bits);
    localparam int cw = $clog2(fifo_depth) + 1;
    localparam int pw = cw + 1;
    localparam int nw = $clog2(buffer_length + 1);
    localparam int bw = buffer_bits + 1;

    seq_state_t state;
    seq_state_t state_next;

    logic [buffer_bits-1:0] next_idx;
    logic [nw-1:0]          issued_cnt;
    logic [nw-1:0]          recv_cnt;
    logic                   inflight;

    logic [cw-1:0]          fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [sw-1:0]          fifo_head;
    logic [pw-1:0]          pending;
    logic                   credit_ok;
    logic                   issue;
    logic                   last_issue;
    logic                   push;
    logic                   pop;
    logic                   accept;

    // A sample issued last cycle has no FIFO entry yet but owns a slot.
    assign pending    = pw'(fifo_count) + pw'(inflight);
    assign credit_ok  = !fifo_full && (pending < pw'(fifo_depth));
    assign issue      = (state == ISSUE) && s_axis_data_tready && credit_ok;
    assign last_issue = issue && (issued_cnt == nw'(buffer_length - 1));
    assign accept     = (state == IDLE) && start;

    // Only a sample that answers our own request is captured; stray valids are dropped.
    assign push = s_axis_data_tvalid && inflight;
    assign pop  = m_axis.tvalid && m_axis.tready;

    assign busy                = (state != IDLE);
    assign m_axis_index_tvalid = issue;
    assign m_axis_index_tdata  = issue ? next_idx : '0;

    assign m_axis.tvalid = !fifo_empty;
    assign m_axis.tdata  = fifo_empty ? '0 : fifo_head[sw-1:1];
    assign m_axis.tlast  = !fifo_empty && fifo_head[0];

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (last_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty && !inflight) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_idx   <= '0;
            issued_cnt <= '0;
            recv_cnt   <= '0;
            inflight   <= 1'b0;
        end else begin
            inflight <= issue;
            if (accept) begin
                // Out-of-range lag offsets fall back to the start of the buffer.
                next_idx   <= ({1'b0, start_index} < bw'(buffer_length)) ? start_index : '0;
                issued_cnt <= '0;
                recv_cnt   <= '0;
            end else begin
                if (issue) begin
                    next_idx   <= (next_idx == buffer_bits'(buffer_length - 1)) ? '0 : next_idx + 1'b1;
                    issued_cnt <= issued_cnt + 1'b1;
                end
                if (push) begin
                    recv_cnt <= recv_cnt + 1'b1;
                end
            end
        end
    end

    reference_sample_fifo #(
        .width (sw),
        .depth (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({i, q, recv_cnt == nw'(buffer_length - 1)}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
endmodule

// File: tb/tb_reference_sequencer.sv
// tb/tb_reference_sequencer.sv - scoreboard bench for reference_sequencer
module tb_reference_sequencer;
    import reference_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  start_index = '0;
    logic        busy;
    logic        done;
    logic        idx_tvalid;
    logic [3:0]  idx_tdata;
    logic        data_tready = 1'b1;
    logic        toggle = 1'b0;
    logic        spurious = 1'b0;
    logic        resp_valid;
    logic [11:0] resp_i;
    logic [11:0] resp_q;
    logic        data_tvalid;

    reference_sequencer_if #(.width(24)) m_axis_if ();

    reference_sequencer #(
        .buffer_length (10),
        .buffer_bits   (4),
        .i_bits        (12),
        .q_bits        (12),
        .fifo_depth    (4)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .start_index         (start_index),
        .busy                (busy),
        .done                (done),
        .m_axis_index_tvalid (idx_tvalid),
        .m_axis_index_tdata  (idx_tdata),
        .s_axis_data_tready  (data_tready),
        .i                   (resp_i),
        .q                   (resp_q),
        .s_axis_data_tvalid  (data_tvalid),
        .m_axis              (m_axis_if)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [11:0] ref_i(input logic [3:0] idx);
        return 12'h100 + 12'(idx) * 12'h011;
    endfunction

    function automatic logic [11:0] ref_q(input logic [3:0] idx);
        return 12'hF00 - 12'(idx);
    endfunction

    // Reference buffer: answers every accepted index exactly one cycle later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_i     <= '0;
            resp_q     <= '0;
        end else begin
            resp_valid <= idx_tvalid && data_tready;
            resp_i     <= ref_i(idx_tdata);
            resp_q     <= ref_q(idx_tdata);
        end
    end
    assign data_tvalid = resp_valid | spurious;

    always @(posedge clk) begin
        #1 data_tready = toggle ? ~data_tready : 1'b1;
    end

    logic [24:0] exp_q[$];
    int  issued_total = 0;
    int  beats        = 0;
    int  done_cnt     = 0;
    int  run          = 0;
    bit  prev_issue   = 0;
    bit  hold_prev    = 0;
    bit  last_xfer_prev = 0;
    logic [23:0] prev_data;
    logic        prev_last;

    // Monitor: pops the scoreboard on every transfer.
    always @(negedge clk) begin
        logic [24:0] e;
        bit xfer;
        if (rst) begin
            hold_prev      = 0;
            last_xfer_prev = 0;
            prev_issue     = 0;
        end else begin
            if (dut.push && dut.fifo_full) check_eq("fifo_overflow", 1, 0);
            if (idx_tvalid) begin
                check_eq("issue_when_ready", 32'(data_tready), 1);
                run = prev_issue ? run + 1 : 1;
                issued_total++;
            end
            prev_issue = idx_tvalid;
            if (hold_prev) begin
                check_eq("stable_valid", 32'(m_axis_if.tvalid), 1);
                check_eq("stable_data", 32'(m_axis_if.tdata), 32'(prev_data));
                check_eq("stable_last", 32'(m_axis_if.tlast), 32'(prev_last));
            end
            hold_prev = m_axis_if.tvalid && !m_axis_if.tready;
            prev_data = m_axis_if.tdata;
            prev_last = m_axis_if.tlast;
            if (done) begin
                check_eq("done_after_last", 32'(last_xfer_prev), 1);
                done_cnt++;
            end
            xfer = m_axis_if.tvalid && m_axis_if.tready;
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", 32'(m_axis_if.tdata), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("beat_data", 32'(m_axis_if.tdata), 32'(e[24:1]));
                    check_eq("beat_last", 32'(m_axis_if.tlast), 32'(e[0]));
                end
                beats++;
            end
            last_xfer_prev = xfer && m_axis_if.tlast;
        end
    end

    task automatic push_expected(input int si);
        int s;
        logic [3:0] idx;
        s = (si >= 10) ? 0 : si;
        for (int k = 0; k < 10; k++) begin
            idx = 4'((s + k) % 10);
            exp_q.push_back({ref_i(idx), ref_q(idx), k == 9});
        end
    endtask

    task automatic pulse_start(input logic [3:0] si);
        @(posedge clk);
        #1 start = 1'b1;
        start_index = si;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int c = 0;
        while (done_cnt == d0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        check_eq("done_seen", 32'(done_cnt - d0), 1);
    endtask

    task automatic run_sweep(input int si);
        int b0, i0, d0;
        b0 = beats; i0 = issued_total; d0 = done_cnt;
        push_expected(si);
        pulse_start(4'(si));
        wait_done(d0, 300);
        check_eq("sweep_issues", 32'(issued_total - i0), 10);
        check_eq("sweep_beats", 32'(beats - b0), 10);
        check_eq("sweep_queue_empty", 32'(exp_q.size()), 0);
    endtask

    task automatic wait_beats(input int target);
        int c = 0;
        while (beats < target && c < 300) begin
            @(posedge clk);
            c++;
        end
        check_eq("beats_reached", 32'(beats >= target), 1);
    endtask

    initial begin
        int b0, i0, d0;
        m_axis_if.tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_idx_valid", 32'(idx_tvalid), 0);
        check_eq("rst_tvalid", 32'(m_axis_if.tvalid), 0);
        check_eq("rst_tdata", 32'(m_axis_if.tdata), 0);
        check_eq("rst_tlast", 32'(m_axis_if.tlast), 0);
        rst = 1'b0;

        // Straight sweep from index 0
        b0 = beats; i0 = issued_total; d0 = done_cnt;
        push_expected(0);
        pulse_start(4'd0);
        check_eq("busy_after_start", 32'(busy), 1);
        check_eq("first_index", 32'(idx_tdata), 0);
        wait_done(d0, 300);
        check_eq("consecutive_issue", 32'(run), 10);
        check_eq("t1_beats", 32'(beats - b0), 10);
        check_eq("t1_issues", 32'(issued_total - i0), 10);
        @(posedge clk); #1;
        check_eq("busy_after_done", 32'(busy), 0);

        // Stray sample valid while idle must not reach the output
        spurious = 1'b1;
        repeat (3) @(posedge clk);
        #1 spurious = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_eq("spurious_ignored", 32'(m_axis_if.tvalid), 0);

        // Wrapping sweep
        run_sweep(7);

        // Downstream backpressure mid-sweep
        b0 = beats; i0 = issued_total; d0 = done_cnt;
        push_expected(2);
        pulse_start(4'd2);
        wait_beats(b0 + 3);
        #1 m_axis_if.tready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("stall_outstanding", 32'((issued_total - i0) - (beats - b0)), 4);
        check_eq("stall_tvalid", 32'(m_axis_if.tvalid), 1);
        m_axis_if.tready = 1'b1;
        wait_done(d0, 300);
        check_eq("stall_beats", 32'(beats - b0), 10);
        check_eq("stall_queue_empty", 32'(exp_q.size()), 0);

        // Index-side ready toggling every cycle
        toggle = 1'b1;
        run_sweep(4);
        toggle = 1'b0;
        repeat (2) @(posedge clk);

        // Reset mid-sweep
        b0 = beats;
        push_expected(0);
        pulse_start(4'd0);
        wait_beats(b0 + 4);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_done", 32'(done), 0);
        check_eq("midrst_idx_valid", 32'(idx_tvalid), 0);
        check_eq("midrst_idx_data", 32'(idx_tdata), 0);
        check_eq("midrst_tvalid", 32'(m_axis_if.tvalid), 0);
        check_eq("midrst_tdata", 32'(m_axis_if.tdata), 0);
        check_eq("midrst_tlast", 32'(m_axis_if.tlast), 0);
        exp_q.delete();
        d0 = done_cnt;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_eq("midrst_no_done", 32'(done_cnt - d0), 0);
        run_sweep(3);

        // Out-of-range start index, plus a start while busy
        b0 = beats; i0 = issued_total; d0 = done_cnt;
        push_expected(12);
        pulse_start(4'd12);
        repeat (2) @(posedge clk);
        pulse_start(4'd5);
        wait_done(d0, 300);
        repeat (15) @(posedge clk);
        #1;
        check_eq("busy_start_one_done", 32'(done_cnt - d0), 1);
        check_eq("busy_start_beats", 32'(beats - b0), 10);
        check_eq("busy_start_issues", 32'(issued_total - i0), 10);
        check_eq("busy_start_idle", 32'(busy), 0);
        check_eq("busy_start_queue", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
